// File: rtl/chip8_alu_seq.sv
// chip8_alu_seq
// Runs one CHIP-8 8XYN register-to-register ALU instruction against a
// single-port V-register file. The file has one combinational read port and
// one write port, so the instruction takes several cycles: read Vx, read Vy,
// write the result to Vx, then (for flag ops) write the flag to VF.
//
// Ports
//   clk       in   system clock, rising edge
//   nrst      in   asynchronous active-low reset
//   start     in   execute request, sampled only in IDLE
//   op        in   N nibble of 8XYN
//   xi, yi    in   X / Y register indices
//   rf_rdata  in   register file read data (combinational from rf_addr)
//   rf_addr   out  register file address
//   rf_wdata  out  register file write data
//   rf_wren   out  register file write enable
//   busy      out  high in RDX, RDY, WRX, WRF
//   done      out  one-cycle completion pulse
//   illegal   out  valid with done; op was not a defined 8XYN
//
// All outputs are registers loaded with the values for the state being
// entered, so nothing combinational reaches them from start/op/xi/yi.
module chip8_alu_seq #(
    parameter bit SHIFT_USES_VY = 1'b0
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       start,
    input  logic [3:0] op,
    input  logic [3:0] xi,
    input  logic [3:0] yi,
    input  logic [7:0] rf_rdata,
    output logic [3:0] rf_addr,
    output logic [7:0] rf_wdata,
    output logic       rf_wren,
    output logic       busy,
    output logic       done,
    output logic       illegal
);

    typedef enum logic [2:0] {IDLE, RDX, RDY, WRX, WRF, FIN} state_t;

    state_t     state_q;
    logic [3:0] op_q, xi_q, yi_q;
    logic [7:0] vx_q, vy_q;
    logic [3:0] addr_q;
    logic [7:0] wdata_q;
    logic       wren_q, busy_q, done_q, illegal_q;

    function automatic logic is_legal(input logic [3:0] o);
        return (o <= 4'h7) || (o == 4'hE);
    endfunction

    function automatic logic has_flag(input logic [3:0] o);
        return (o == 4'h4) || (o == 4'h5) || (o == 4'h6) ||
               (o == 4'h7) || (o == 4'hE);
    endfunction

    // Returns {flag, result}.
    function automatic logic [8:0] alu(input logic [3:0] o,
                                       input logic [7:0] a,
                                       input logic [7:0] b);
        logic [7:0] src;
        logic [8:0] r;
        src = SHIFT_USES_VY ? b : a;
        case (o)
            4'h0:    r = {1'b0, b};
            4'h1:    r = {1'b0, a | b};
            4'h2:    r = {1'b0, a & b};
            4'h3:    r = {1'b0, a ^ b};
            4'h4:    r = {1'b0, a} + {1'b0, b};
            4'h5:    r = {a >= b, a - b};
            4'h7:    r = {b >= a, b - a};
            4'h6:    r = {src[0], 1'b0, src[7:1]};
            4'hE:    r = {src[7], src[6:0], 1'b0};
            default: r = 9'd0;
        endcase
        return r;
    endfunction

    // In RDY the Vy value is still on rf_rdata (not yet latched), so the
    // result registered for WRX is computed from it directly. The flag is
    // computed in WRX from the latched operands, so the Vx write cannot
    // disturb it.
    logic [8:0] alu_rd_d, alu_wr_d;
    assign alu_rd_d = alu(op_q, vx_q, rf_rdata);
    assign alu_wr_d = alu(op_q, vx_q, vy_q);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            xi_q      <= '0;
            yi_q      <= '0;
            vx_q      <= '0;
            vy_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wren_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q <= op;
                        xi_q <= xi;
                        yi_q <= yi;
                        if (is_legal(op)) begin
                            state_q <= RDX;
                            addr_q  <= xi;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q   <= FIN;
                            done_q    <= 1'b1;
                            illegal_q <= 1'b1;
                        end
                    end
                end
                RDX: begin
                    vx_q    <= rf_rdata;
                    state_q <= RDY;
                    addr_q  <= yi_q;
                end
                RDY: begin
                    vy_q    <= rf_rdata;
                    state_q <= WRX;
                    addr_q  <= xi_q;
                    wren_q  <= 1'b1;
                    wdata_q <= alu_rd_d[7:0];
                end
                WRX: begin
                    if (has_flag(op_q)) begin
                        state_q <= WRF;
                        addr_q  <= 4'hF;
                        wren_q  <= 1'b1;
                        wdata_q <= {7'b0, alu_wr_d[8]};
                    end else begin
                        state_q <= FIN;
                        addr_q  <= '0;
                        wren_q  <= 1'b0;
                        wdata_q <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                WRF: begin
                    state_q <= FIN;
                    addr_q  <= '0;
                    wren_q  <= 1'b0;
                    wdata_q <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                FIN: begin
                    // start here is deliberately ignored; it is taken in IDLE.
                    state_q   <= IDLE;
                    done_q    <= 1'b0;
                    illegal_q <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    addr_q    <= '0;
                    wren_q    <= 1'b0;
                    wdata_q   <= '0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    illegal_q <= 1'b0;
                end
            endcase
        end
    end

    assign rf_addr  = addr_q;
    assign rf_wdata = wdata_q;
    assign rf_wren  = wren_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_chip8_alu_seq.sv
// Bench for chip8_alu_seq: two instances (shift source Vx and Vy), each with
// its own behavioural register file. Vectors come from a table; expected
// results are pushed to a scoreboard queue at start and popped at done.
module tb_chip8_alu_seq;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [1:0] start = 2'b00;
    logic [3:0] op = '0, xi = '0, yi = '0;

    logic [3:0] a0, a1;
    logic [7:0] wd0, wd1, rd0, rd1;
    logic [1:0] wren, busy, done, ill;

    logic [7:0] rf0 [16];
    logic [7:0] rf1 [16];
    logic       ld_en = 1'b0;
    logic [3:0] ld_a = '0;
    logic [7:0] ld_d = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    chip8_alu_seq #(.SHIFT_USES_VY(1'b0)) u_dut0 (
        .clk(clk), .nrst(nrst), .start(start[0]), .op(op), .xi(xi), .yi(yi),
        .rf_rdata(rd0), .rf_addr(a0), .rf_wdata(wd0), .rf_wren(wren[0]),
        .busy(busy[0]), .done(done[0]), .illegal(ill[0]));

    chip8_alu_seq #(.SHIFT_USES_VY(1'b1)) u_dut1 (
        .clk(clk), .nrst(nrst), .start(start[1]), .op(op), .xi(xi), .yi(yi),
        .rf_rdata(rd1), .rf_addr(a1), .rf_wdata(wd1), .rf_wren(wren[1]),
        .busy(busy[1]), .done(done[1]), .illegal(ill[1]));

    assign rd0 = rf0[a0];
    assign rd1 = rf1[a1];

    always @(posedge clk) begin
        if (wren[0]) rf0[a0] <= wd0;
        else if (ld_en) rf0[ld_a] <= ld_d;
        if (wren[1]) rf1[a1] <= wd1;
        else if (ld_en) rf1[ld_a] <= ld_d;
    end

    typedef struct {
        logic       sel;
        logic [3:0] op, x, y;
        logic [7:0] vx, vy, ex, ef;
        int         lat;
        logic       ill;
    } vec_t;

    vec_t vecs[$];
    vec_t sbq[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] rd(input logic sel, input logic [3:0] a);
        return sel ? rf1[a] : rf0[a];
    endfunction

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        ld_a = a; ld_d = d; ld_en = 1'b1;
        @(posedge clk); #1 ld_en = 1'b0;
    endtask

    task automatic add(input logic sel, input logic [3:0] o, x, y,
                       input logic [7:0] vx, vy, ex, ef,
                       input int lat, input logic il);
        vec_t v;
        v.sel = sel; v.op = o; v.x = x; v.y = y; v.vx = vx; v.vy = vy;
        v.ex = ex; v.ef = ef; v.lat = lat; v.ill = il;
        vecs.push_back(v);
    endtask

    // inj: pulse extra starts (op 0, X=3, Y=4) mid-instruction and in FIN;
    // both must be ignored.
    task automatic run(input vec_t v, input bit inj);
        vec_t e;
        int cyc, nw, nb;
        load(4'hF, 8'h5A);
        load(v.x, v.vx);
        load(v.y, v.vy);
        if (inj) load(4'h3, 8'h77);
        op = v.op; xi = v.x; yi = v.y;
        start[v.sel] = 1'b1;
        sbq.push_back(v);
        @(posedge clk); #1 start = 2'b00;
        cyc = 1; nw = 0; nb = 0;
        while (!done[v.sel] && cyc < 20) begin
            if (wren[v.sel]) nw++;
            if (busy[v.sel]) nb++;
            if (inj && cyc == 2) begin
                op = 4'h0; xi = 4'h3; yi = 4'h4; start[v.sel] = 1'b1;
            end
            @(posedge clk); #1 start = 2'b00;
            cyc++;
        end
        e = sbq.pop_front();
        chk("done_seen", int'(done[v.sel]), 1);
        if (busy[v.sel]) nb++;
        if (wren[v.sel]) nw++;
        chk("latency", cyc, e.lat);
        chk("illegal", int'(ill[v.sel]), int'(e.ill));
        chk("vx_after", rd(v.sel, e.x), e.ex);
        chk("vf_after", rd(v.sel, 4'hF), e.ef);
        chk("wr_count", nw, (e.lat == 5) ? 2 : (e.lat == 4) ? 1 : 0);
        chk("busy_cycles", nb, (e.lat > 1) ? e.lat - 1 : 0);
        if (inj) begin
            op = 4'h0; xi = 4'h3; yi = 4'h4; start[v.sel] = 1'b1;
        end
        @(posedge clk); #1 start = 2'b00;
        if (inj) begin
            chk("fin_start_ignored_busy", int'(busy[v.sel]), 0);
            chk("fin_start_ignored_done", int'(done[v.sel]), 0);
            chk("busy_start_ignored_v3", rd(v.sel, 4'h3), 8'h77);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        vec_t v;
        int nw;
        //   sel op    x     y     vx     vy     ex     ef    lat ill
        add(0, 4'h4, 4'h1, 4'h2, 8'hF0, 8'h20, 8'h10, 8'h01, 5, 0);
        add(0, 4'h5, 4'h3, 4'h4, 8'h05, 8'h05, 8'h00, 8'h01, 5, 0);
        add(0, 4'h5, 4'h3, 4'h4, 8'h04, 8'h05, 8'hFF, 8'h00, 5, 0);
        add(0, 4'hE, 4'hF, 4'h1, 8'h81, 8'h00, 8'h01, 8'h01, 5, 0);
        add(1, 4'h6, 4'h6, 4'h7, 8'h03, 8'h80, 8'h40, 8'h00, 5, 0);
        add(0, 4'h2, 4'h8, 4'h9, 8'hCC, 8'hAA, 8'h88, 8'h5A, 4, 0);
        add(0, 4'h9, 4'h1, 4'h2, 8'h11, 8'h22, 8'h11, 8'h5A, 1, 1);
        add(0, 4'hF, 4'h1, 4'h2, 8'h11, 8'h22, 8'h11, 8'h5A, 1, 1);
        add(0, 4'h0, 4'h1, 4'h2, 8'h12, 8'h34, 8'h34, 8'h5A, 4, 0);
        add(0, 4'h1, 4'h1, 4'h2, 8'h0F, 8'hF0, 8'hFF, 8'h5A, 4, 0);
        add(0, 4'h3, 4'h1, 4'h2, 8'hFF, 8'h0F, 8'hF0, 8'h5A, 4, 0);
        add(0, 4'h7, 4'h1, 4'h2, 8'h10, 8'h30, 8'h20, 8'h01, 5, 0);
        add(0, 4'h6, 4'h5, 4'h2, 8'h03, 8'h80, 8'h01, 8'h01, 5, 0);
        add(0, 4'hE, 4'h5, 4'h2, 8'h80, 8'h01, 8'h00, 8'h01, 5, 0);
        add(0, 4'h4, 4'h1, 4'h1, 8'h80, 8'h80, 8'h00, 8'h01, 5, 0);
        add(0, 4'h4, 4'h1, 4'h2, 8'h01, 8'h02, 8'h03, 8'h00, 5, 0);
        add(0, 4'h7, 4'h1, 4'h2, 8'h30, 8'h10, 8'hE0, 8'h00, 5, 0);

        for (int i = 0; i < 16; i++) begin
            rf0[i] = 8'h00; rf1[i] = 8'h00;
        end

        // Reset state
        #12;
        chk("rst_addr", int'(a0), 0);
        chk("rst_wdata", int'(wd0), 0);
        chk("rst_ctl", int'({wren[0], busy[0], done[0], ill[0]}), 0);
        @(posedge clk); #1 nrst = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) run(vecs[i], 1'b0);

        // Extra starts while busy and while in FIN are ignored.
        add(0, 4'h4, 4'h1, 4'h2, 8'hF0, 8'h20, 8'h10, 8'h01, 5, 0);
        v = vecs[$];
        run(v, 1'b1);

        // Reset in RDY aborts with no writes.
        load(4'hF, 8'h5A); load(4'h1, 8'hF0); load(4'h2, 8'h20);
        op = 4'h4; xi = 4'h1; yi = 4'h2; start[0] = 1'b1;
        @(posedge clk); #1 start = 2'b00;
        @(posedge clk); #1;
        chk("pre_rst_busy", int'(busy[0]), 1);
        nrst = 1'b0;
        #1;
        chk("abort_addr", int'(a0), 0);
        chk("abort_wdata", int'(wd0), 0);
        chk("abort_ctl", int'({wren[0], busy[0], done[0], ill[0]}), 0);
        nw = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (wren[0] || done[0]) nw++;
        end
        nrst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (wren[0] || done[0]) nw++;
        end
        chk("abort_no_activity", nw, 0);
        chk("abort_v1", rd(0, 4'h1), 8'hF0);
        chk("abort_vf", rd(0, 4'hF), 8'h5A);
        run(v, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
